// File: rtl/amstrad_mem_arbiter.sv
// rtl/amstrad_mem_arbiter.sv - phase-slotted SDRAM arbiter for video, CPU and loader
module amstrad_mem_arbiter #(
    parameter int TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        ce_4p,
    input  logic        cpu_req,
    input  logic        cpu_wr,
    input  logic [22:0] cpu_addr,
    input  logic [7:0]  cpu_dout,
    output logic [7:0]  cpu_din,
    output logic        cpu_wait_n,
    input  logic        vid_req,
    input  logic [14:0] vid_addr,
    output logic [15:0] vid_data,
    output logic        vid_valid,
    input  logic        ldr_req,
    input  logic [22:0] ldr_addr,
    input  logic [7:0]  ldr_data,
    output logic        ldr_ack,
    output logic        sd_req,
    output logic        sd_we,
    output logic [22:0] sd_addr,
    output logic [7:0]  sd_din,
    input  logic [15:0] sd_dout,
    input  logic        sd_ack,
    output logic        err
);

    typedef enum logic [2:0] {IDLE, VID, CPU, LDR, DONE} state_t;

    state_t      state, state_nxt, owner;
    logic [1:0]  phase;
    logic [3:0]  cnt;
    logic        rr_ldr;
    logic        wait_pend;
    logic        cpu_req_d;
    logic        in_grant;
    logic        tmo_hit;
    logic        grant;

    assign in_grant = (state == VID) || (state == CPU) || (state == LDR);
    assign tmo_hit  = (cnt == 4'(TIMEOUT - 1));
    assign grant    = (state == IDLE) && (state_nxt != IDLE);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nxt;
    end

    // Phase 0 belongs to video alone; contested CPU/loader slots alternate via rr_ldr.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (ce_4p) begin
                    if (phase == 2'd0) begin
                        if (vid_req) state_nxt = VID;
                    end else if (cpu_req && (!ldr_req || !rr_ldr)) begin
                        state_nxt = CPU;
                    end else if (ldr_req) begin
                        state_nxt = LDR;
                    end
                end
            end
            VID, CPU, LDR: begin
                if (sd_ack || tmo_hit) state_nxt = DONE;
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        vid_valid  = (state == DONE) && (owner == VID);
        ldr_ack    = (state == DONE) && (owner == LDR);
        cpu_wait_n = !(wait_pend || (state == CPU));
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            phase     <= 2'd0;
            cnt       <= 4'd0;
            rr_ldr    <= 1'b0;
            owner     <= IDLE;
            sd_req    <= 1'b0;
            sd_we     <= 1'b0;
            sd_addr   <= 23'd0;
            sd_din    <= 8'd0;
            cpu_din   <= 8'hFF;
            vid_data  <= 16'd0;
            err       <= 1'b0;
            wait_pend <= 1'b0;
            cpu_req_d <= 1'b0;
        end else begin
            cpu_req_d <= cpu_req;
            if (ce_4p) phase <= phase + 2'd1;
            sd_req <= grant;

            if (grant) begin
                owner <= state_nxt;
                cnt   <= 4'd0;
                case (state_nxt)
                    VID: begin
                        sd_addr <= {8'h00, vid_addr};
                        sd_we   <= 1'b0;
                        sd_din  <= 8'h00;
                    end
                    CPU: begin
                        sd_addr <= cpu_addr;
                        sd_we   <= cpu_wr;
                        sd_din  <= cpu_dout;
                        rr_ldr  <= 1'b1;
                    end
                    LDR: begin
                        sd_addr <= ldr_addr;
                        sd_we   <= 1'b1;
                        sd_din  <= ldr_data;
                        rr_ldr  <= 1'b0;
                    end
                    default: ;
                endcase
            end else if (in_grant) begin
                cnt <= cnt + 4'd1;
            end

            // A timed-out read completes with all-ones data rather than stale bus contents.
            if (in_grant && (sd_ack || tmo_hit)) begin
                if (!sd_ack) err <= 1'b1;
                if (state == VID) vid_data <= sd_ack ? sd_dout : 16'hFFFF;
                if (state == CPU && !sd_we) cpu_din <= sd_ack ? sd_dout[7:0] : 8'hFF;
            end

            if (state == CPU && state_nxt == DONE) wait_pend <= 1'b0;
            else if (cpu_req && !cpu_req_d)        wait_pend <= 1'b1;
        end
    end

endmodule

// File: tb/tb_amstrad_mem_arbiter.sv
// tb/tb_amstrad_mem_arbiter.sv - self-checking bench for amstrad_mem_arbiter
module tb_amstrad_mem_arbiter;

    localparam int TIMEOUT = 15;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        ce_4p = 1'b0;
    logic        cpu_req, cpu_wr;
    logic [22:0] cpu_addr;
    logic [7:0]  cpu_dout, cpu_din;
    logic        cpu_wait_n;
    logic        vid_req;
    logic [14:0] vid_addr;
    logic [15:0] vid_data;
    logic        vid_valid;
    logic        ldr_req;
    logic [22:0] ldr_addr;
    logic [7:0]  ldr_data;
    logic        ldr_ack;
    logic        sd_req, sd_we;
    logic [22:0] sd_addr;
    logic [7:0]  sd_din;
    logic [15:0] sd_dout = 16'h0000;
    logic        sd_ack = 1'b0;
    logic        err;

    amstrad_mem_arbiter #(.TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .reset_n(reset_n), .ce_4p(ce_4p),
        .cpu_req(cpu_req), .cpu_wr(cpu_wr), .cpu_addr(cpu_addr), .cpu_dout(cpu_dout),
        .cpu_din(cpu_din), .cpu_wait_n(cpu_wait_n),
        .vid_req(vid_req), .vid_addr(vid_addr), .vid_data(vid_data), .vid_valid(vid_valid),
        .ldr_req(ldr_req), .ldr_addr(ldr_addr), .ldr_data(ldr_data), .ldr_ack(ldr_ack),
        .sd_req(sd_req), .sd_we(sd_we), .sd_addr(sd_addr), .sd_din(sd_din),
        .sd_dout(sd_dout), .sd_ack(sd_ack), .err(err)
    );

    typedef struct {
        int          kind;
        int          phase;
        logic        wr;
        logic [22:0] addr;
        logic [7:0]  wdata;
        logic [15:0] rdata;
        int          delay;
        logic [22:0] exp_addr;
        logic        exp_we;
        logic [7:0]  exp_din;
        logic [15:0] exp_res;
        logic        exp_err;
    } vec_t;

    typedef struct {
        logic [22:0] addr;
        logic        we;
        logic [7:0]  din;
        logic        chk_din;
    } req_t;

    typedef struct {
        int          delay;
        logic [15:0] data;
    } mem_t;

    req_t        exp_req[$];
    mem_t        mem_q[$];
    logic [15:0] vid_exp[$];
    vec_t        vecs[7];

    int checks = 0;
    int fails  = 0;
    int cyc    = 0;
    int req_cyc = 0;
    int vid_cnt = 0;
    int ldr_cnt = 0;
    int cd = 0;
    logic [15:0] cur_data = 16'h0000;
    logic [1:0]  ce_div = 2'd0;
    logic [1:0]  mphase;
    logic        prev_req = 1'b0, prev_vv = 1'b0, prev_la = 1'b0;
    req_t        mon_r;
    mem_t        mem_m;

    always #5 clk = ~clk;

    always @(negedge clk) begin
        ce_div = ce_div + 2'd1;
        ce_4p  = (ce_div == 2'd0);
    end

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n)   mphase <= 2'd0;
        else if (ce_4p) mphase <= mphase + 2'd1;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        fails++;
        $display("FAIL %s: bounded wait expired without the required event", name);
    endtask

    // Memory model: acks 'delay' clocks after the request pulse; delay 0 never acks.
    always @(negedge clk) begin
        sd_ack  = 1'b0;
        sd_dout = 16'($urandom);
        if (!reset_n) begin
            cd = 0;
        end else begin
            if (cd > 0) begin
                cd--;
                if (cd == 0) begin
                    sd_ack  = 1'b1;
                    sd_dout = cur_data;
                end
            end
            if (sd_req && mem_q.size() > 0) begin
                mem_m    = mem_q.pop_front();
                cd       = mem_m.delay;
                cur_data = mem_m.data;
            end
        end
    end

    always @(negedge clk) begin
        if (reset_n) begin
            if (sd_req) begin
                check("sd_req_one_clock", prev_req, 0);
                req_cyc = cyc;
                if (exp_req.size() == 0) begin
                    fail_now("sd_req_unexpected");
                end else begin
                    mon_r = exp_req.pop_front();
                    check("sd_addr", sd_addr, mon_r.addr);
                    check("sd_we", sd_we, mon_r.we);
                    if (mon_r.chk_din) check("sd_din", sd_din, mon_r.din);
                end
            end
            if (vid_valid) begin
                check("vid_valid_one_clock", prev_vv, 0);
                if (vid_exp.size() == 0) fail_now("vid_valid_unexpected");
                else check("vid_data", vid_data, vid_exp.pop_front());
                vid_cnt++;
            end
            if (ldr_ack) begin
                check("ldr_ack_one_clock", prev_la, 0);
                ldr_cnt++;
            end
        end
        prev_req = sd_req;
        prev_vv  = vid_valid;
        prev_la  = ldr_ack;
    end

    task automatic check_reset(input string tag);
        check({tag, "_sd_req"}, sd_req, 0);
        check({tag, "_sd_we"}, sd_we, 0);
        check({tag, "_sd_addr"}, sd_addr, 0);
        check({tag, "_sd_din"}, sd_din, 0);
        check({tag, "_cpu_din"}, cpu_din, 8'hFF);
        check({tag, "_cpu_wait_n"}, cpu_wait_n, 1);
        check({tag, "_vid_data"}, vid_data, 0);
        check({tag, "_vid_valid"}, vid_valid, 0);
        check({tag, "_ldr_ack"}, ldr_ack, 0);
        check({tag, "_err"}, err, 0);
    endtask

    // Returns at negedge+1 just before a ce_4p edge evaluated in the given phase.
    task automatic wait_slot(input int p);
        int n = 0;
        do begin
            @(negedge clk); #1;
            n++;
        end while (!(ce_4p && mphase == 2'(p)) && n < 80);
        if (!(ce_4p && mphase == 2'(p))) fail_now("wait_slot");
    endtask

    task automatic push_txn(input logic [22:0] a, input logic we, input logic [7:0] din,
                            input logic chk, input int dly, input logic [15:0] rd);
        req_t r;
        mem_t m;
        r.addr = a; r.we = we; r.din = din; r.chk_din = chk;
        m.delay = dly; m.data = rd;
        exp_req.push_back(r);
        mem_q.push_back(m);
    endtask

    task automatic run_vec(input vec_t v);
        int n = 0;
        int base;
        wait_slot(v.phase);
        push_txn(v.exp_addr, v.exp_we, v.exp_din, v.kind != 0, v.delay, v.rdata);
        case (v.kind)
            0: begin
                base = vid_cnt;
                vid_exp.push_back(v.exp_res);
                vid_addr = v.addr[14:0];
                vid_req  = 1'b1;
                while (vid_cnt == base && n < 64) begin @(negedge clk); #1; n++; end
                vid_req = 1'b0;
                if (vid_cnt == base) fail_now("vid_done");
            end
            1: begin
                cpu_addr = v.addr; cpu_wr = v.wr; cpu_dout = v.wdata;
                cpu_req  = 1'b1;
                @(negedge clk); #1;
                check("cpu_wait_n_low", cpu_wait_n, 0);
                while (!cpu_wait_n && n < 64) begin @(negedge clk); #1; n++; end
                cpu_req = 1'b0;
                if (!cpu_wait_n) fail_now("cpu_done");
                check("cpu_din", cpu_din, v.exp_res[7:0]);
            end
            default: begin
                base = ldr_cnt;
                ldr_addr = v.addr; ldr_data = v.wdata;
                ldr_req  = 1'b1;
                while (ldr_cnt == base && n < 64) begin @(negedge clk); #1; n++; end
                ldr_req = 1'b0;
                if (ldr_cnt == base) fail_now("ldr_done");
            end
        endcase
        check("err_after_vec", err, v.exp_err);
        check("req_served", exp_req.size(), 0);
    endtask

    task automatic contest(input int ng, input bit cpu_first);
        bit c = cpu_first;
        int n_ldr = 0;
        int base = ldr_cnt;
        int n = 0;
        wait_slot(1);
        for (int i = 0; i < ng; i++) begin
            if (c) push_txn(23'h000111, 1'b0, 8'h22, 1'b1, 1, 16'h0044);
            else begin
                push_txn(23'h000222, 1'b1, 8'h33, 1'b1, 1, 16'h0000);
                n_ldr++;
            end
            c = !c;
        end
        cpu_addr = 23'h000111; cpu_wr = 1'b0; cpu_dout = 8'h22;
        ldr_addr = 23'h000222; ldr_data = 8'h33;
        cpu_req = 1'b1; ldr_req = 1'b1;
        while (exp_req.size() != 0 && n < 100) begin @(negedge clk); #1; n++; end
        cpu_req = 1'b0; ldr_req = 1'b0;
        if (exp_req.size() != 0) fail_now("contest_grants");
        repeat (8) @(negedge clk);
        #1;
        check("contest_ldr_acks", ldr_cnt - base, n_ldr);
        check("contest_cpu_din", cpu_din, 8'h44);
    endtask

    initial begin
        int n;
        int base;
        int g;
        reset_n = 1'b0;
        cpu_req = 1'b0; cpu_wr = 1'b0; cpu_addr = '0; cpu_dout = '0;
        vid_req = 1'b0; vid_addr = '0;
        ldr_req = 1'b0; ldr_addr = '0; ldr_data = '0;

        vecs[0] = '{0, 0, 1'b0, 23'h001234, 8'h00, 16'hBEEF, 3, 23'h001234, 1'b0, 8'h00, 16'hBEEF, 1'b0};
        vecs[1] = '{1, 1, 1'b0, 23'h004000, 8'h00, 16'h00A5, 2, 23'h004000, 1'b0, 8'h00, 16'h00A5, 1'b0};
        vecs[2] = '{1, 2, 1'b1, 23'h7FFFFF, 8'h5A, 16'h9999, 1, 23'h7FFFFF, 1'b1, 8'h5A, 16'h00A5, 1'b0};
        vecs[3] = '{2, 3, 1'b1, 23'h123456, 8'h3C, 16'h0000, 4, 23'h123456, 1'b1, 8'h3C, 16'h0000, 1'b0};
        vecs[4] = '{0, 0, 1'b0, 23'h007FFF, 8'h00, 16'h1357, 1, 23'h007FFF, 1'b0, 8'h00, 16'h1357, 1'b0};
        vecs[5] = '{1, 1, 1'b0, 23'h400001, 8'hC3, 16'hAB12, 5, 23'h400001, 1'b0, 8'hC3, 16'h0012, 1'b0};
        vecs[6] = '{0, 0, 1'b0, 23'h000000, 8'h00, 16'h5555, 0, 23'h000000, 1'b0, 8'h00, 16'hFFFF, 1'b1};

        repeat (3) @(negedge clk);
        #1;
        check_reset("rst");
        reset_n = 1'b1;

        for (int i = 0; i < 7; i++) run_vec(vecs[i]);

        // Last CPU/loader grant was the CPU, so the loader wins the first contest.
        contest(2, 1'b0);

        // CPU read that is never acknowledged.
        wait_slot(1);
        push_txn(23'h004321, 1'b0, 8'h77, 1'b1, 0, 16'h0000);
        cpu_addr = 23'h004321; cpu_wr = 1'b0; cpu_dout = 8'h77;
        cpu_req = 1'b1;
        n = 0;
        do begin
            @(negedge clk); #1;
            if (!cpu_wait_n) n++;
        end while (!cpu_wait_n && n < 40);
        cpu_req = 1'b0;
        check("timeout_clocks", n, TIMEOUT);
        check("timeout_err", err, 1);
        check("timeout_cpu_din", cpu_din, 8'hFF);

        // Reset pulsed while a loader write is waiting for its ack.
        wait_slot(2);
        push_txn(23'h0AAAAA, 1'b1, 8'h11, 1'b1, 0, 16'h0000);
        ldr_addr = 23'h0AAAAA; ldr_data = 8'h11;
        base = ldr_cnt;
        ldr_req = 1'b1;
        repeat (5) @(negedge clk);
        #1;
        reset_n = 1'b0;
        ldr_req = 1'b0;
        #1;
        check_reset("midrst");
        repeat (3) @(negedge clk);
        #1;
        reset_n = 1'b1;
        repeat (8) @(negedge clk);
        #1;
        check("midrst_no_ldr_ack", ldr_cnt, base);
        check("midrst_err_clear", err, 0);

        contest(3, 1'b1);

        // CPU access started in phase 3 runs past the next phase-0 slot.
        wait_slot(3);
        push_txn(23'h000333, 1'b0, 8'h00, 1'b1, 6, 16'h0011);
        push_txn(23'h000055, 1'b0, 8'h00, 1'b0, 1, 16'h2468);
        vid_exp.push_back(16'h2468);
        cpu_addr = 23'h000333; cpu_wr = 1'b0; cpu_dout = 8'h00;
        cpu_req = 1'b1;
        @(negedge clk); #1;
        g = req_cyc;
        base = vid_cnt;
        vid_addr = 15'h0055;
        vid_req = 1'b1;
        n = 0;
        while (!cpu_wait_n && n < 64) begin @(negedge clk); #1; n++; end
        cpu_req = 1'b0;
        if (!cpu_wait_n) fail_now("overrun_cpu_done");
        check("overrun_cpu_din", cpu_din, 8'h11);
        n = 0;
        while (vid_cnt == base && n < 64) begin @(negedge clk); #1; n++; end
        vid_req = 1'b0;
        if (vid_cnt == base) fail_now("overrun_vid_done");
        check("overrun_vid_grant_delay", req_cyc - g, 20);

        repeat (4) @(negedge clk);
        #1;
        check("queues_drained", exp_req.size() + mem_q.size() + vid_exp.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

endmodule
